sqrt_ctrl_fsm: RTL and testbench

//  Control unit for the 5-bit magnitude/square-root datapath.

---
 rtl/sqrt_ctrl_fsm_pkg.sv | 59 +++++
 rtl/sqrt_ctrl_fsm_if.sv | 51 +++++
 rtl/sqrt_ctrl_decode.sv | 69 ++++++
 rtl/sqrt_ctrl_fsm.sv | 89 ++++++++
 tb/tb_sqrt_ctrl_fsm.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_ctrl_fsm_pkg.sv
// sqrt_ctrl_fsm_pkg: shared definitions for the magnitude/square-root controller.
//   - state encodings (StIdle..StDone) and the state register width
//   - AU1 / AU2 op codes
//   - packed 20-bit control word driven to the datapath
// Optional feature macro used by files importing this package: SQRT_CTRL_ABORT_EN.
package sqrt_ctrl_fsm_pkg;

    localparam int unsigned StateW = 4;

    typedef enum logic [StateW-1:0] {
        StIdle = 4'd0,
        StLoad = 4'd1,
        StAbs1 = 4'd2,
        StAbs2 = 4'd3,
        StMax  = 4'd4,
        StMin  = 4'd5,
        StSub  = 4'd6,
        StAdd  = 4'd7,
        StMaxF = 4'd8,
        StDone = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        Au1AbsA = 2'b00,
        Au1AbsB = 2'b01,
        Au1Max  = 2'b10,
        Au1Min  = 2'b11
    } au1_op_e;

    typedef enum logic [1:0] {
        Au2Sub   = 2'b00,
        Au2Add   = 2'b01,
        Au2Max   = 2'b10,
        Au2PassA = 2'b11
    } au2_op_e;

    // 20-bit control word, MSB first.
    typedef struct packed {
        logic    in1_tri;
        logic    in2_tri;
        logic    r1_e;
        logic    r2_e;
        logic    r1_tri;
        logic    r2_tri;
        au1_op_e au1_op;
        logic    au1_tri;
        logic    au1_tri1;
        logic    shift3_tri;
        logic    r3_e;
        logic    r4_e;
        logic    r5_e;
        logic    r4_tri;
        logic    r5_tri;
        au2_op_e au2_op;
        logic    au2_tri;
        logic    done;
    } ctrl_t;

endpackage

// File: rtl/sqrt_ctrl_fsm_if.sv
// sqrt_ctrl_fsm_if: handshake and datapath-control bundle of the sqrt controller.
//   master : controller side (receives start[/abort], drives busy, enables, op codes, done)
//   slave  : datapath / requester side
// Optional feature macro: SQRT_CTRL_ABORT_EN adds the abort request line after start.
interface sqrt_ctrl_fsm_if;

    logic       start;
`ifdef SQRT_CTRL_ABORT_EN
    logic       abort;
`endif
    logic       busy;
    logic       In1_tri;
    logic       In2_tri;
    logic       R1_e;
    logic       R2_e;
    logic       R1_tri;
    logic       R2_tri;
    logic [1:0] AU1_op;
    logic       AU1_tri;
    logic       AU1_tri1;
    logic       shift3_tri;
    logic       R3_e;
    logic       R4_e;
    logic       R5_e;
    logic       R4_tri;
    logic       R5_tri;
    logic [1:0] AU2_op;
    logic       AU2_tri;
    logic       done;

    modport master (
        input  start,
`ifdef SQRT_CTRL_ABORT_EN
        input  abort,
`endif
        output busy, In1_tri, In2_tri, R1_e, R2_e, R1_tri, R2_tri, AU1_op, AU1_tri,
               AU1_tri1, shift3_tri, R3_e, R4_e, R5_e, R4_tri, R5_tri, AU2_op, AU2_tri,
               done
    );

    modport slave (
        output start,
`ifdef SQRT_CTRL_ABORT_EN
        output abort,
`endif
        input  busy, In1_tri, In2_tri, R1_e, R2_e, R1_tri, R2_tri, AU1_op, AU1_tri,
               AU1_tri1, shift3_tri, R3_e, R4_e, R5_e, R4_tri, R5_tri, AU2_op, AU2_tri,
               done
    );

endinterface

// File: rtl/sqrt_ctrl_decode.sv
// sqrt_ctrl_decode: purely combinational state -> 20-bit control word decode.
//   state_i : controller state
//   ctrl_o  : datapath enables, tri-state selects, op codes and done
// Unused encodings decode to an all-zero word.
module sqrt_ctrl_decode
    import sqrt_ctrl_fsm_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            StIdle: ctrl_o = '0;
            StLoad: begin
                ctrl_o.in1_tri = 1'b1;
                ctrl_o.in2_tri = 1'b1;
                ctrl_o.r1_e    = 1'b1;
                ctrl_o.r2_e    = 1'b1;
            end
            StAbs1: begin
                ctrl_o.au1_op  = Au1AbsA;
                ctrl_o.au1_tri = 1'b1;
                ctrl_o.r1_e    = 1'b1;
            end
            StAbs2: begin
                ctrl_o.au1_op   = Au1AbsB;
                ctrl_o.r2_tri   = 1'b1;
                ctrl_o.au1_tri1 = 1'b1;
                ctrl_o.r2_e     = 1'b1;
            end
            StMax: begin
                // x lands in R4 and x>>3 in R3 on the same edge
                ctrl_o.au1_op     = Au1Max;
                ctrl_o.r2_tri     = 1'b1;
                ctrl_o.shift3_tri = 1'b1;
                ctrl_o.r3_e       = 1'b1;
                ctrl_o.r4_e       = 1'b1;
            end
            StMin: begin
                ctrl_o.au1_op = Au1Min;
                ctrl_o.r2_tri = 1'b1;
                ctrl_o.r5_e   = 1'b1;
            end
            StSub: begin
                ctrl_o.r4_tri  = 1'b1;
                ctrl_o.au2_op  = Au2Sub;
                ctrl_o.au2_tri = 1'b1;
                ctrl_o.r3_e    = 1'b1;
            end
            StAdd: begin
                ctrl_o.r5_tri  = 1'b1;
                ctrl_o.au2_op  = Au2Add;
                ctrl_o.au2_tri = 1'b1;
                ctrl_o.r3_e    = 1'b1;
            end
            StMaxF: begin
                ctrl_o.r4_tri  = 1'b1;
                ctrl_o.au2_op  = Au2Max;
                ctrl_o.au2_tri = 1'b1;
                ctrl_o.r3_e    = 1'b1;
            end
            StDone: ctrl_o.done = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/sqrt_ctrl_fsm.sv
// sqrt_ctrl_fsm: Moore control unit for the 5-bit magnitude/sqrt datapath,
// out ~= max(x - x/8 + y/2, x) with x = max(|a|,|b|), y = min(|a|,|b|).
//   clk   : system clock, rising edge
//   clear : asynchronous active-low reset
//   bus   : sqrt_ctrl_fsm_if.master (start[, abort] in; busy, datapath controls, done out)
// Optional feature macro: SQRT_CTRL_ABORT_EN adds an abort request that returns the
// sequence to idle from any state other than idle/done.
// Outputs are registered: the control word for the next state is decoded ahead and
// captured alongside the state, so every output is a pure function of the state flops.
module sqrt_ctrl_fsm
    import sqrt_ctrl_fsm_pkg::*;
(
    input  logic            clk,
    input  logic            clear,
    sqrt_ctrl_fsm_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   busy_q, busy_d;
    logic   abort_req;

`ifdef SQRT_CTRL_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (bus.start) state_d = StLoad;
            StLoad:  state_d = StAbs1;
            StAbs1:  state_d = StAbs2;
            StAbs2:  state_d = StMax;
            StMax:   state_d = StMin;
            StMin:   state_d = StSub;
            StSub:   state_d = StAdd;
            StAdd:   state_d = StMaxF;
            StMaxF:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Abort overrides sequencing, but never the idle start decision or the done cycle.
        if (abort_req && (state_q != StIdle) && (state_q != StDone)) begin
            state_d = StIdle;
        end
    end

    sqrt_ctrl_decode u_decode (
        .state_i (state_d),
        .ctrl_o  (ctrl_d)
    );

    assign busy_d = (state_d != StIdle);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
            ctrl_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.In1_tri    = ctrl_q.in1_tri;
    assign bus.In2_tri    = ctrl_q.in2_tri;
    assign bus.R1_e       = ctrl_q.r1_e;
    assign bus.R2_e       = ctrl_q.r2_e;
    assign bus.R1_tri     = ctrl_q.r1_tri;
    assign bus.R2_tri     = ctrl_q.r2_tri;
    assign bus.AU1_op     = ctrl_q.au1_op;
    assign bus.AU1_tri    = ctrl_q.au1_tri;
    assign bus.AU1_tri1   = ctrl_q.au1_tri1;
    assign bus.shift3_tri = ctrl_q.shift3_tri;
    assign bus.R3_e       = ctrl_q.r3_e;
    assign bus.R4_e       = ctrl_q.r4_e;
    assign bus.R5_e       = ctrl_q.r5_e;
    assign bus.R4_tri     = ctrl_q.r4_tri;
    assign bus.R5_tri     = ctrl_q.r5_tri;
    assign bus.AU2_op     = ctrl_q.au2_op;
    assign bus.AU2_tri    = ctrl_q.au2_tri;
    assign bus.done       = ctrl_q.done;

endmodule

// File: tb/tb_sqrt_ctrl_fsm.sv
// tb_sqrt_ctrl_fsm: directed bench for sqrt_ctrl_fsm with a small behavioural datapath
// attached, so the full sequence is checked end to end (3,4 -> 5 etc.).
module tb_sqrt_ctrl_fsm;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    sqrt_ctrl_fsm_if bus ();

    sqrt_ctrl_fsm dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Observed control word, fixed bench ordering.
    logic [19:0] obs;
    assign obs = {bus.In1_tri, bus.In2_tri, bus.R1_e, bus.R2_e,
                  bus.R1_tri, bus.R2_tri, bus.AU1_op,
                  bus.AU1_tri, bus.AU1_tri1, bus.shift3_tri, bus.R3_e,
                  bus.R4_e, bus.R5_e, bus.R4_tri, bus.R5_tri,
                  bus.AU2_op, bus.AU2_tri, bus.done};

    // ---------------- behavioural datapath ----------------
    logic [4:0] in1, in2;
    logic [4:0] r1, r2, r3, r4, r5;
    logic [4:0] au1_b, au1_y, au2_a, au2_y;

    function automatic logic [4:0] abs5(input logic [4:0] v);
        return v[4] ? (~v + 5'd1) : v;
    endfunction

    always_comb begin
        au1_b = bus.R2_tri ? r2 : (bus.R1_tri ? r1 : 5'd0);
        case (bus.AU1_op)
            2'b00:   au1_y = abs5(r1);
            2'b01:   au1_y = abs5(au1_b);
            2'b10:   au1_y = (r1 > au1_b) ? r1 : au1_b;
            default: au1_y = (r1 < au1_b) ? r1 : au1_b;
        endcase
        au2_a = bus.R4_tri ? r4 : (bus.R5_tri ? r5 : 5'd0);
        case (bus.AU2_op)
            2'b00:   au2_y = au2_a - r3;
            2'b01:   au2_y = au2_a + r3;
            2'b10:   au2_y = (au2_a > r3) ? au2_a : r3;
            default: au2_y = au2_a;
        endcase
    end

    always @(posedge clk) begin
        if (bus.R1_e) r1 <= bus.In2_tri ? in2 : (bus.AU1_tri ? au1_y : 5'd0);
        if (bus.R2_e) r2 <= bus.In1_tri ? in1 : (bus.AU1_tri1 ? au1_y : 5'd0);
        if (bus.R3_e) r3 <= bus.shift3_tri ? (au1_y >> 3) : (bus.AU2_tri ? au2_y : 5'd0);
        if (bus.R4_e) r4 <= au1_y;
        if (bus.R5_e) r5 <= au1_y >> 1;
    end

    // ---------------- per-cycle invariants ----------------
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        n_run++;
        if ((bus.In2_tri && bus.AU1_tri) || (bus.In1_tri && bus.AU1_tri1) ||
            (bus.R1_tri && bus.R2_tri) || (bus.R4_tri && bus.R5_tri) ||
            (bus.shift3_tri && bus.AU2_tri)) begin
            n_fail++;
            $display("FAIL bus_invariant t=%0t ctrl=%b required no shared-bus pair high",
                     $time, obs);
        end
        n_run++;
        if (bus.done && done_prev) begin
            n_fail++;
            $display("FAIL done_pulse t=%0t done high 2 cycles, required 1", $time);
        end
        done_prev = bus.done;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear = 1'b0;
        repeat (2) @(negedge clk);
        n_run++;
        if (obs !== 20'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state ctrl=%b busy=%b required all 0", obs, bus.busy);
        end
        clear = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sequence();
        logic [19:0] exp_tab [9];
        exp_tab[0] = 20'b1111_0000_0000_0000_0000; // LOAD
        exp_tab[1] = 20'b0010_0000_1000_0000_0000; // ABS1
        exp_tab[2] = 20'b0001_0101_0100_0000_0000; // ABS2
        exp_tab[3] = 20'b0000_0110_0011_1000_0000; // MAX
        exp_tab[4] = 20'b0000_0111_0000_0100_0000; // MIN
        exp_tab[5] = 20'b0000_0000_0001_0010_0010; // SUB
        exp_tab[6] = 20'b0000_0000_0001_0001_0110; // ADD
        exp_tab[7] = 20'b0000_0000_0001_0010_1010; // MAXF
        exp_tab[8] = 20'b0000_0000_0000_0000_0001; // DONE
        in1 = 5'd3;
        in2 = 5'd4;
        bus.start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            n_run++;
            if (obs !== exp_tab[c-1] || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_state%0d ctrl=%b busy=%b required ctrl=%b busy=1",
                         c, obs, bus.busy, exp_tab[c-1]);
            end
        end
        @(negedge clk);
        n_run++;
        if (obs !== 20'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_back_idle ctrl=%b busy=%b required all 0", obs, bus.busy);
        end
    endtask

    task automatic run_op(input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] exp_out, input string name);
        int got_c;
        logic [4:0] got_out;
        got_c   = 0;
        got_out = 'x;
        in1 = a;
        in2 = b;
        bus.start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (bus.done) begin
                got_c   = c;
                got_out = r3;
                break;
            end
        end
        n_run++;
        if (got_c != 9) begin
            n_fail++;
            $display("FAIL %s_latency done at cycle %0d required 9 (0 = timeout)", name, got_c);
        end
        n_run++;
        if (got_out !== exp_out) begin
            n_fail++;
            $display("FAIL %s_result out=%0d required %0d", name, got_out, exp_out);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic saw_done;
        in1 = 5'd3;
        in2 = 5'd4;
        bus.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        n_run++;
        if (bus.AU2_tri !== 1'b1 || bus.R4_tri !== 1'b1 || bus.AU2_op !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_reach_sub ctrl=%b required S_SUB controls", obs);
        end
        #2 clear = 1'b0;
        #1;
        n_run++;
        if (obs !== 20'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_sub ctrl=%b busy=%b required all 0", obs, bus.busy);
        end
        @(negedge clk);
        clear = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        n_run++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard done/busy seen=%b required 0", saw_done);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done, exp_busy;
        in1 = 5'd3;
        in2 = 5'd4;
        bus.start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            exp_done = ((c % 10) == 9);
            exp_busy = ((c % 10) != 0);
            n_run++;
            if (bus.done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_done c=%0d done=%b required %b", c, bus.done, exp_done);
            end
            n_run++;
            if (bus.busy !== exp_busy) begin
                n_fail++;
                $display("FAIL b2b_busy c=%0d busy=%b required %b", c, bus.busy, exp_busy);
            end
            if (exp_done) begin
                n_run++;
                if (r3 !== 5'd5) begin
                    n_fail++;
                    $display("FAIL b2b_result c=%0d out=%0d required 5", c, r3);
                end
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
    endtask

`ifdef SQRT_CTRL_ABORT_EN
    task automatic test_abort();
        logic saw_done;
        in1 = 5'd3;
        in2 = 5'd4;
        bus.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
        end
        n_run++;
        if (bus.R5_e !== 1'b1 || bus.AU1_op !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_reach_min ctrl=%b required S_MIN controls", obs);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_run++;
        if (obs !== 20'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_to_idle ctrl=%b busy=%b required all 0", obs, bus.busy);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        n_run++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done done seen=%b required 0", saw_done);
        end
        // Abort alongside start in idle is ignored.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_run++;
        if (bus.busy !== 1'b1 || obs !== 20'b1111_0000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL abort_with_start busy=%b ctrl=%b required busy=1 LOAD", bus.busy, obs);
        end
        repeat (10) @(negedge clk);
        run_op(5'd3, 5'd4, 5'd5, "after_abort");
    endtask
`endif

    initial begin
        bus.start = 1'b0;
`ifdef SQRT_CTRL_ABORT_EN
        bus.abort = 1'b0;
`endif
        in1 = 5'd0;
        in2 = 5'd0;
        test_reset();
        test_sequence();
        run_op(5'd3,  5'd4, 5'd5,  "op_3_4");
        run_op(5'h18, 5'd6, 5'd10, "op_m8_6");
        run_op(5'd0,  5'd0, 5'd0,  "op_0_0");
        run_op(5'd7,  5'd0, 5'd7,  "op_7_0");
        test_reset_mid_op();
        test_back_to_back();
`ifdef SQRT_CTRL_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

endmodule
